// File: rtl/cache_refill_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl_pkg
//
// Shared definitions for the cache refill controller: FSM state encoding,
// AXI burst constants, address field widths and a helper that extracts one
// 32-bit word from a packed cache line.
//
// The cache line and tag widths are the values def_cache.vh provides
// (`CACHELINE_WIDTH = 512, `TAG_WIDTH = 20). They are defined here only
// when no earlier file has done so, so this slice also builds standalone.
//
// Optional feature macro used by the controller: CACHE_REFILL_WRITEBACK_EN.
// ---------------------------------------------------------------------------
`ifndef CACHELINE_WIDTH
`define CACHELINE_WIDTH 512
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 20
`endif

package cache_refill_ctrl_pkg;

    // Refill sequencer states. The write-back states (WB_RD .. B) are only
    // reachable when the write-back feature is built in.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WB_RD  = 4'd1,
        WB_CAP = 4'd2,
        AW     = 4'd3,
        W      = 4'd4,
        B      = 4'd5,
        AR     = 4'd6,
        R      = 4'd7,
        FILL   = 4'd8
    } refill_state_t;

    // AXI burst type and beat size used for every line transfer.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    // Address layout: {tag, index, 6-bit byte offset within a 64-byte line}.
    localparam int WORD_BITS      = 32;
    localparam int OFFSET_BITS    = 6;
    localparam int LINE_ADDR_BITS = 32 - OFFSET_BITS;
    localparam int INDEX_BITS     = LINE_ADDR_BITS - `TAG_WIDTH;

    // Word idx of a packed line; word 0 sits in bits [31:0].
    function automatic logic [WORD_BITS-1:0] line_word(
        input logic [`CACHELINE_WIDTH-1:0] line,
        input int                          idx
    );
        return line[idx*WORD_BITS +: WORD_BITS];
    endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
//
// Services one cache miss at a time. On a miss the line address (and the
// victim's tag) are latched; a dirty victim is first read out of the data
// array and written back over AXI as a 16-beat INCR burst, then the missing
// line is fetched with a 16-beat INCR read burst and handed to the data
// array with a one-cycle refresh strobe.
//
// Optional feature: define CACHE_REFILL_WRITEBACK_EN to build the dirty
// write-back path. Without it every miss goes straight to the read burst,
// victim_dirty is ignored and the AXI write channel stays idle.
//
// Parameters
//   LINE_WORDS    words per cache line / AXI beats per burst (16)
//   AXI_ID        constant ID driven on AR and AW
//
// Ports
//   clk, rst                 sole clock, asynchronous active-high reset
//   miss_req/miss_addr       one-cycle miss pulse and line address
//   victim_dirty/victim_tag  state of the line being replaced
//   busy, done               refill in progress, one-cycle completion
//   write_back/cacheline_old victim read strobe, data valid a cycle later
//   refresh/cacheline_new    line-fill strobe and fill data
//   ar*/r*                   AXI read address and read data channels
//   aw*/w*/b*                AXI write address, write data, write response
// ---------------------------------------------------------------------------
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int         LINE_WORDS = 16,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        miss_req,
    input  logic [31:0]                 miss_addr,
    input  logic                        victim_dirty,
    input  logic [`TAG_WIDTH-1:0]       victim_tag,
    output logic                        busy,
    output logic                        done,

    output logic                        write_back,
    input  logic [`CACHELINE_WIDTH-1:0] cacheline_old,
    output logic                        refresh,
    output logic [`CACHELINE_WIDTH-1:0] cacheline_new,

    output logic [3:0]                  arid,
    output logic [31:0]                 araddr,
    output logic [7:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [31:0]                 rdata,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready,

    output logic [3:0]                  awid,
    output logic [31:0]                 awaddr,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [31:0]                 wdata,
    output logic [3:0]                  wstrb,
    output logic                        wlast,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic                        bvalid,
    output logic                        bready
);

    localparam logic [3:0] LAST_BEAT = 4'(LINE_WORDS - 1);
    localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);

    refill_state_t             state;
    logic [LINE_ADDR_BITS-1:0] line_addr;
    logic [3:0]                rbeat;
    logic [WORD_BITS-1:0]      fill_buf [LINE_WORDS];
    logic                      unused_inputs;

`ifdef CACHE_REFILL_WRITEBACK_EN
    logic [`TAG_WIDTH-1:0]     victim_tag_q;
    logic [3:0]                wbeat;
    logic [WORD_BITS-1:0]      wr_buf [LINE_WORDS];
`endif

    // Burst shape is identical for every transfer, so the attribute fields
    // are constants; only the addresses depend on the latched miss.
    assign arid    = AXI_ID;
    assign arlen   = BURST_LEN;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign araddr  = {line_addr, {OFFSET_BITS{1'b0}}};

    assign awid    = AXI_ID;
    assign awlen   = BURST_LEN;
    assign awsize  = AXI_SIZE_4B;
    assign awburst = AXI_BURST_INCR;
    assign wstrb   = 4'hF;

`ifdef CACHE_REFILL_WRITEBACK_EN
    // The victim lives at the same index as the missing line but under its
    // own tag. wdata follows the beat counter, which only moves on a
    // handshake, so the payload stays put while wready is low.
    assign awaddr = {victim_tag_q, line_addr[INDEX_BITS-1:0], {OFFSET_BITS{1'b0}}};
    assign wdata  = wr_buf[wbeat];
    assign unused_inputs = ^miss_addr[OFFSET_BITS-1:0];
`else
    // Write-back path not built: the write channel is held idle and the
    // victim-related inputs are deliberately left unused.
    assign awaddr     = '0;
    assign wdata      = '0;
    assign write_back = 1'b0;
    assign awvalid    = 1'b0;
    assign wvalid     = 1'b0;
    assign wlast      = 1'b0;
    assign bready     = 1'b0;
    assign unused_inputs = ^{miss_addr[OFFSET_BITS-1:0], victim_dirty, victim_tag,
                             cacheline_old, awready, wready, bvalid};
`endif

    // Present the fill buffer as one packed line, word 0 in the low bits.
    always_comb begin
        cacheline_new = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            cacheline_new[k*WORD_BITS +: WORD_BITS] = fill_buf[k];
        end
    end

    // Line buffers carry no reset: their contents are only consumed after
    // they have been fully written during the current refill.
    always_ff @(posedge clk) begin
        if (state == R && rvalid && rready) begin
            fill_buf[rbeat] <= rdata;
        end
`ifdef CACHE_REFILL_WRITEBACK_EN
        if (state == WB_CAP) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                wr_buf[k] <= line_word(cacheline_old, k);
            end
        end
`endif
    end

    // Refill sequencer. Every strobe and valid is a register that is set on
    // entry to the state that owns it and cleared when its handshake (or its
    // single cycle) completes, so AXI valids never drop before ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            line_addr  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            refresh    <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            rbeat      <= 4'd0;
`ifdef CACHE_REFILL_WRITEBACK_EN
            victim_tag_q <= '0;
            write_back   <= 1'b0;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            wlast        <= 1'b0;
            bready       <= 1'b0;
            wbeat        <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        line_addr <= miss_addr[31:OFFSET_BITS];
                        busy      <= 1'b1;
`ifdef CACHE_REFILL_WRITEBACK_EN
                        victim_tag_q <= victim_tag;
                        if (victim_dirty) begin
                            write_back <= 1'b1;
                            state      <= WB_RD;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= AR;
                        end
`else
                        arvalid <= 1'b1;
                        state   <= AR;
`endif
                    end
                end

`ifdef CACHE_REFILL_WRITEBACK_EN
                // The data array answers the read strobe one cycle later,
                // which is exactly the cycle spent in WB_CAP.
                WB_RD: begin
                    write_back <= 1'b0;
                    state      <= WB_CAP;
                end

                WB_CAP: begin
                    awvalid <= 1'b1;
                    state   <= AW;
                end

                AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wbeat   <= 4'd0;
                        wlast   <= (LAST_BEAT == 4'd0);
                        state   <= W;
                    end
                end

                W: begin
                    if (wready) begin
                        if (wlast) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            state  <= B;
                        end else begin
                            wbeat <= wbeat + 4'd1;
                            wlast <= (wbeat + 4'd1 == LAST_BEAT);
                        end
                    end
                end

                B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        arvalid <= 1'b1;
                        state   <= AR;
                    end
                end
`endif

                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        rbeat   <= 4'd0;
                        state   <= R;
                    end
                end

                // The burst ends on rlast or on the last word, whichever
                // comes first, so the counter can never wrap.
                R: begin
                    if (rvalid) begin
                        if (rlast || rbeat == LAST_BEAT) begin
                            rready  <= 1'b0;
                            refresh <= 1'b1;
                            done    <= 1'b1;
                            state   <= FILL;
                        end else begin
                            rbeat <= rbeat + 4'd1;
                        end
                    end
                end

                FILL: begin
                    refresh <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_refill_ctrl
//
// Directed bench for cache_refill_ctrl. Acts as the data array and as an
// AXI slave, optionally throttling every channel, and records what the
// controller did during each refill for comparison against hand-computed
// expectations. Honours CACHE_REFILL_WRITEBACK_EN the same way the design
// does.
// ---------------------------------------------------------------------------
`ifndef CACHELINE_WIDTH
`define CACHELINE_WIDTH 512
`endif

module tb_cache_refill_ctrl;

    localparam int LW = 16;
`ifdef CACHE_REFILL_WRITEBACK_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    logic                        clk;
    logic                        rst;
    logic                        miss_req;
    logic [31:0]                 miss_addr;
    logic                        victim_dirty;
    logic [19:0]                 victim_tag;
    logic                        busy;
    logic                        done;
    logic                        write_back;
    logic [`CACHELINE_WIDTH-1:0] cacheline_old;
    logic                        refresh;
    logic [`CACHELINE_WIDTH-1:0] cacheline_new;
    logic [3:0]                  arid;
    logic [31:0]                 araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arvalid;
    logic                        arready;
    logic [31:0]                 rdata;
    logic                        rlast;
    logic                        rvalid;
    logic                        rready;
    logic [3:0]                  awid;
    logic [31:0]                 awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awvalid;
    logic                        awready;
    logic [31:0]                 wdata;
    logic [3:0]                  wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        wready;
    logic                        bvalid;
    logic                        bready;

    cache_refill_ctrl #(.LINE_WORDS(16), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .busy(busy), .done(done),
        .write_back(write_back), .cacheline_old(cacheline_old),
        .refresh(refresh), .cacheline_new(cacheline_new),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        dirty;
        logic [19:0] tag;
        logic [31:0] old_base;
        logic [31:0] r_base;
        logic        stall;
        logic        extra_miss;
        int          rst_beat;
        logic [31:0] exp_araddr;
        logic [31:0] exp_awaddr;
        int          exp_wb;
    } vec_t;

    vec_t vecs [5];

    int tests_run;
    int tests_failed;

    int wb_count, aw_count, w_count, b_count, ar_count, r_count;
    int refresh_count, done_count, done_with_refresh;
    int busy_errors, hold_errors, wdata_errors, wlast_errors;
    int ar_cyc, b_cyc;
    logic [31:0] awaddr_seen, araddr_seen;
    logic [16:0] aw_attr, ar_attr;
    logic [`CACHELINE_WIDTH-1:0] line_seen;
    bit rst_taken;

    function automatic logic [`CACHELINE_WIDTH-1:0] build_line(input logic [31:0] base);
        logic [`CACHELINE_WIDTH-1:0] l;
        l = '0;
        for (int k = 0; k < LW; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkLine(input logic [`CACHELINE_WIDTH-1:0] actual,
                             input logic [`CACHELINE_WIDTH-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL cacheline_new: got %h, expected %h", actual, expected);
        end
    endtask

    task automatic idleInputs();
        miss_req      = 1'b0;
        arready       = 1'b0;
        rvalid        = 1'b0;
        rlast         = 1'b0;
        rdata         = '0;
        awready       = 1'b0;
        wready        = 1'b0;
        bvalid        = 1'b0;
        cacheline_old = '0;
    endtask

    // Issues one miss and plays data array plus AXI slave cycle by cycle.
    // Inputs change on the falling edge, so a handshake seen here completes
    // on the following rising edge.
    task automatic applyStimulus(input vec_t v);
        int   cyc, aw_wait, ar_wait, b_wait, trail, r_beat;
        bit   prev_wb, b_pend, r_active, hold_valid;
        logic [31:0] held_data;
        wb_count = 0; aw_count = 0; w_count = 0; b_count = 0; ar_count = 0;
        r_count = 0; refresh_count = 0; done_count = 0; done_with_refresh = 0;
        busy_errors = 0; hold_errors = 0; wdata_errors = 0; wlast_errors = 0;
        ar_cyc = -1; b_cyc = -1; awaddr_seen = '0; araddr_seen = '0;
        aw_attr = '0; ar_attr = '0; line_seen = '0; rst_taken = 0;
        aw_wait = 0; ar_wait = 0; b_wait = 0; trail = 0; r_beat = 0;
        prev_wb = 0; b_pend = 0; r_active = 0; hold_valid = 0; held_data = '0;

        @(negedge clk);
        miss_req     = 1'b1;
        miss_addr    = v.addr;
        victim_dirty = v.dirty;
        victim_tag   = v.tag;
        cyc = 0;
        while (cyc < 400 && trail < 3) begin
            @(negedge clk);
            miss_req = 1'b0;
            if (v.extra_miss && cyc == 4) begin
                miss_req     = 1'b1;
                miss_addr    = 32'h5555_5580;
                victim_dirty = 1'b1;
                victim_tag   = 20'h0F0F0;
            end

            if (v.rst_beat >= 0 && r_active && r_beat == v.rst_beat) begin
                #2 rst = 1'b1;
                #1;
                checkOutput("rst_busy", 32'(busy), 32'd0);
                checkOutput("rst_strobes",
                            32'({done, refresh, arvalid, rready, write_back,
                                 awvalid, wvalid, wlast, bready}), 32'd0);
                idleInputs();
                rst_taken = 1;
                @(negedge clk);
                rst = 1'b0;
                break;
            end

            cacheline_old = prev_wb ? build_line(v.old_base) : {16{32'hDEAD_BEEF}};
            prev_wb = write_back;
            if (write_back) wb_count++;
            if (done_count == 0 && !busy) busy_errors++;
            if (refresh) begin
                refresh_count++;
                line_seen = cacheline_new;
                if (done) done_with_refresh++;
            end
            if (done) done_count++;
            if (done_count > 0) trail++;

            awready = !v.stall || aw_wait >= 2;
            if (awvalid && awready) begin
                aw_count++;
                awaddr_seen = awaddr;
                aw_attr = {awid, awlen, awsize, awburst};
                aw_wait = 0;
            end else if (awvalid) begin
                aw_wait++;
            end

            wready = !v.stall || (cyc % 2) == 1;
            if (wvalid) begin
                if (hold_valid && wdata != held_data) hold_errors++;
                if (wready) begin
                    if (wdata != v.old_base + 32'(w_count)) wdata_errors++;
                    if (wstrb != 4'hF) wdata_errors++;
                    if (wlast != (w_count == LW - 1)) wlast_errors++;
                    w_count++;
                    hold_valid = 0;
                    if (wlast) begin
                        b_pend = 1;
                        b_wait = 0;
                    end
                end else begin
                    hold_valid = 1;
                    held_data  = wdata;
                end
            end

            bvalid = b_pend && (!v.stall || b_wait >= 2);
            if (b_pend && !bvalid) b_wait++;
            if (bvalid && bready) begin
                b_count++;
                b_pend = 0;
                b_cyc  = cyc;
            end

            if (r_active) begin
                rvalid = !v.stall || (cyc % 3) != 0;
                rdata  = v.r_base + 32'(r_beat);
                rlast  = (r_beat == LW - 1);
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
            if (rvalid && rready) begin
                r_count++;
                r_beat++;
                if (r_beat == LW) r_active = 0;
            end

            arready = !v.stall || ar_wait >= 2;
            if (arvalid && arready) begin
                ar_count++;
                araddr_seen = araddr;
                ar_attr = {arid, arlen, arsize, arburst};
                ar_cyc = cyc;
                r_active = 1;
                r_beat = 0;
                ar_wait = 0;
            end else if (arvalid) begin
                ar_wait++;
            end
            cyc++;
        end
        @(negedge clk);
        idleInputs();
    endtask

    task automatic checkVector(input vec_t v);
        if (v.rst_beat < 0) begin
            checkOutput("done_count", 32'(done_count), 32'd1);
            checkOutput("refresh_count", 32'(refresh_count), 32'd1);
            checkOutput("done_with_refresh", 32'(done_with_refresh), 32'd1);
            checkOutput("r_beats", 32'(r_count), 32'(LW));
            checkLine(line_seen, build_line(v.r_base));
            checkOutput("busy_during", 32'(busy_errors), 32'd0);
            checkOutput("busy_after", 32'(busy), 32'd0);
        end
        checkOutput("ar_count", 32'(ar_count), 32'd1);
        checkOutput("araddr", araddr_seen, v.exp_araddr);
        checkOutput("ar_attr", 32'(ar_attr), 32'({4'd0, 8'd15, 3'b010, 2'b01}));
        checkOutput("write_back_pulses", 32'(wb_count), 32'(v.exp_wb));
        checkOutput("aw_count", 32'(aw_count), 32'(v.exp_wb));
        checkOutput("w_beats", 32'(w_count), 32'(v.exp_wb * LW));
        checkOutput("b_count", 32'(b_count), 32'(v.exp_wb));
        if (v.exp_wb != 0) begin
            checkOutput("awaddr", awaddr_seen, v.exp_awaddr);
            checkOutput("aw_attr", 32'(aw_attr), 32'({4'd0, 8'd15, 3'b010, 2'b01}));
            checkOutput("wdata_order", 32'(wdata_errors), 32'd0);
            checkOutput("wlast_position", 32'(wlast_errors), 32'd0);
            checkOutput("wdata_hold", 32'(hold_errors), 32'd0);
            checkOutput("ar_after_b", 32'(ar_cyc > b_cyc), 32'd1);
        end
    endtask

    initial begin
        vec_t rv;
        tests_run    = 0;
        tests_failed = 0;
        miss_addr    = '0;
        victim_dirty = 1'b0;
        victim_tag   = '0;
        idleInputs();

        vecs[0] = '{addr: 32'h1000_0040, dirty: 1'b0, tag: 20'h00000,
                    old_base: 32'h0, r_base: 32'h0, stall: 1'b0, extra_miss: 1'b0,
                    rst_beat: -1, exp_araddr: 32'h1000_0040, exp_awaddr: 32'h0,
                    exp_wb: 0};
        vecs[1] = '{addr: 32'h1000_0055, dirty: 1'b1, tag: 20'hABCDE,
                    old_base: 32'h0000_00A0, r_base: 32'h0000_0100, stall: 1'b0,
                    extra_miss: 1'b0, rst_beat: -1, exp_araddr: 32'h1000_0040,
                    exp_awaddr: 32'hABCD_E040, exp_wb: WB};
        vecs[2] = '{addr: 32'h2345_67FF, dirty: 1'b1, tag: 20'h12345,
                    old_base: 32'h7700_0000, r_base: 32'hC0DE_0000, stall: 1'b1,
                    extra_miss: 1'b0, rst_beat: -1, exp_araddr: 32'h2345_67C0,
                    exp_awaddr: 32'h1234_57C0, exp_wb: WB};
        vecs[3] = '{addr: 32'hFFFF_FFC0, dirty: 1'b0, tag: 20'h00000,
                    old_base: 32'h0, r_base: 32'h3300_0000, stall: 1'b1,
                    extra_miss: 1'b1, rst_beat: -1, exp_araddr: 32'hFFFF_FFC0,
                    exp_awaddr: 32'h0, exp_wb: 0};
        vecs[4] = '{addr: 32'h0000_0000, dirty: 1'b1, tag: 20'hFFFFF,
                    old_base: 32'h6600_0010, r_base: 32'h4400_0000, stall: 1'b0,
                    extra_miss: 1'b1, rst_beat: -1, exp_araddr: 32'h0000_0000,
                    exp_awaddr: 32'hFFFF_F000, exp_wb: WB};

        // Asynchronous reset with no clock edge yet.
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_strobes",
                    32'({done, refresh, arvalid, rready, write_back,
                         awvalid, wvalid, wlast, bready}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
            checkVector(vecs[i]);
        end

        // Reset in the middle of the read burst, then a fresh miss.
        rv = '{addr: 32'h3000_0080, dirty: 1'b0, tag: 20'h00000,
               old_base: 32'h0, r_base: 32'h1111_0000, stall: 1'b0,
               extra_miss: 1'b0, rst_beat: 7, exp_araddr: 32'h3000_0080,
               exp_awaddr: 32'h0, exp_wb: 0};
        applyStimulus(rv);
        checkOutput("rst_taken", 32'(rst_taken), 32'd1);
        checkOutput("rst_no_done", 32'(done_count), 32'd0);
        checkVector(rv);

        rv = '{addr: 32'h0BAD_F00D, dirty: 1'b0, tag: 20'h00000,
               old_base: 32'h0, r_base: 32'h2222_0000, stall: 1'b0,
               extra_miss: 1'b0, rst_beat: -1, exp_araddr: 32'h0BAD_F000,
               exp_awaddr: 32'h0, exp_wb: 0};
        applyStimulus(rv);
        checkVector(rv);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have these parameters: LINE_WORDS, 16, words per cache line and AXI burst beats; AXI_ID, 4'd0, constant ID on AR/AW.
REQ-002 SHALL have clock and reset ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous and active-high.
REQ-003 SHALL have miss-request ports: miss_req  in  1  one-cycle miss pulse; miss_addr  in  32  line address, offset ignored; victim_dirty  in  1  victim line dirty; victim_tag  in  20  victim tag; busy  out  1  refill in progress; done  out  1  one-cycle completion pulse.
REQ-004 SHALL have data-array ports: write_back  out  1  read victim line; cacheline_old  in  `CACHELINE_WIDTH  victim data, valid one cycle after write_back; refresh  out  1  line-fill strobe; cacheline_new  out  `CACHELINE_WIDTH  fill data.
REQ-005 SHALL have AXI read ports: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1 (out); arready 1 (in); rdata 32, rlast 1, rvalid 1 (in); rready 1 (out).
REQ-006 SHALL have AXI write ports: awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1, wdata 32, wstrb 4, wlast 1, wvalid 1, bready 1 (out); awready 1, wready 1, bvalid 1 (in).

Function
REQ-007 SHALL use FSM states IDLE, WB_RD, WB_CAP, AW, W, B, AR, R, FILL.
REQ-008 SHALL, in IDLE with miss_req=1, latch miss_addr[31:6], victim_dirty and victim_tag, then go to WB_RD if victim_dirty=1, else to AR; miss_req SHALL be ignored while busy=1.
REQ-009 SHALL assert write_back for exactly one cycle in WB_RD; WB_CAP SHALL capture cacheline_old into a 512-bit write buffer, then go to AW.
REQ-010 SHALL drive, in AW: awaddr={victim_tag,index,6'b0}, awlen=LINE_WORDS-1, awsize=3'b010, awburst=2'b01 (INCR), awvalid=1 until awready is seen, then go to W.
REQ-011 SHALL drive, in W: wdata=write buffer word[beat], wstrb=4'hF, wvalid=1; beat SHALL increment on wvalid&wready; wlast=1 when beat=LINE_WORDS-1; the final handshake SHALL go to B.
REQ-012 SHALL assert bready=1 in B; bvalid SHALL go to AR; bresp SHALL be ignored.
REQ-013 SHALL drive, in AR: araddr={latched line address,6'b0}, same len/size/burst, arvalid=1 until arready, then go to R.
REQ-014 SHALL assert rready=1 in R; each rvalid beat SHALL write rdata to fill-buffer word[beat] (beat 0 at bits 31:0); a beat with rlast=1 or beat=LINE_WORDS-1 SHALL go to FILL.
REQ-015 SHALL assert refresh=1 for exactly one cycle in FILL with cacheline_new = fill buffer (stable that cycle), assert done=1 in the same cycle, then return to IDLE.
REQ-016 SHALL hold every AXI valid and its payload stable until the handshake completes; a handshake SHALL be counted whenever valid and ready are both 1 in the same cycle.
REQ-017 SHALL drive busy=1 in every state except IDLE.
REQ-018 SHALL use 4-bit beat counters that are cleared on entry to W and to R and never wrap within a burst.

Reset
REQ-019 SHALL, on rst=1 (asynchronous), enter IDLE and drive all valid/ready/strobe outputs, busy and done to 0 and the beat counters to 0; buffer contents are don't-care.
REQ-020 SHALL abandon any outstanding AXI burst when reset is taken mid-operation; the interconnect is reset together with this block.

Configuration
REQ-021 SHALL, with CACHE_REFILL_WRITEBACK_EN defined, implement WB_RD/WB_CAP/AW/W/B as above.
REQ-022 SHALL, without CACHE_REFILL_WRITEBACK_EN, omit those states and the write buffer, go IDLE->AR on every miss, tie write_back, awvalid, wvalid and bready to 0, and ignore victim_dirty.

Structure
REQ-023 SHALL take `CACHELINE_WIDTH and `TAG_WIDTH from def_cache.vh; state encodings and AXI constants (INCR, SIZE_4B) SHALL be added there.
REQ-024 SHALL use no sub-module; the FSM, counters and buffers SHALL be in one module.

Verification
REQ-025 Clean miss, addr 0x1000_0040, arready immediate, 16 rvalid beats with rdata=beat index -> one AR with araddr=0x1000_0040 and arlen=15; refresh pulse; cacheline_new word k = k; done together with refresh.
REQ-026 Dirty miss, victim_tag=0xABCDE, cacheline_old word k=0xA0+k -> write_back pulse; AW awaddr=0xABCDE040 (index 1); 16 W beats in order with wlast on beat 15; B; then AR.
REQ-027 Backpressure: wready toggling 1/0 and rvalid gaps -> no beat lost or duplicated; wdata held during stalls.
REQ-028 miss_req pulsed while busy=1 -> ignored; exactly one AR issued.
REQ-029 rst asserted during beat 7 of R -> outputs reach reset values without a clock edge; next miss starts a fresh AR.
REQ-030 Build without CACHE_REFILL_WRITEBACK_EN, dirty miss -> no write_back or AW; AR issued directly.
